fifo_read_ctrl: RTL and testbench
=================================

# fifo_read_ctrl

Read-side controller for the asynchronous FIFO. Runs entirely in the read clock domain. It takes the write pointer after it has been synchronized into that domain, owns the read pointer and the empty flag, and drives the read address of the FIFO memory. It also captures the memory's combinational read data into a registered output with a valid/ready handshake, so consumers receive one word per `rclk` at full throughput.

## Interface
Parameters:
- `DATASIZE`, 8: data word width; must match the memory.
- `ADDRSIZE`, 4: memory address bits; depth = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.

Ports:
- `rclk` in 1: read clock. One clock only; all state updates on its rising edge.
- `rrst` in 1: reset, synchronous, active-high.
- `rq2_wptr` in ADDRSIZE+1: Gray-coded write pointer, already two-flop synchronized into `rclk`.
- `rdata_mem` in DATASIZE: combinational read data from the memory at `raddr`.
- `raddr` out ADDRSIZE: memory read address (binary).
- `rptr` out ADDRSIZE+1: registered Gray-coded read pointer, exported for synchronization into the write domain.
- `rempty` out 1: registered; memory holds no unread word.
- `rlevel` out ADDRSIZE+1: registered count of unread words in memory, as seen from the read domain (0..2^ADDRSIZE).
- `dout` out DATASIZE: registered output word.
- `dout_valid` out 1: `dout` holds a word not yet accepted.
- `dout_ready` in 1: consumer accepts `dout` in any cycle where `dout_valid && dout_ready`.

## Operation
- State:
  - `rbin`: binary read pointer, ADDRSIZE+1 bits.
  - `rptr`: Gray form of `rbin`.
  - `rempty`, `rlevel`, `dout`, `dout_valid`.
- Fetch condition: `fetch = !rempty && (!dout_valid || dout_ready)`.
- Pointer update: `rbinnext = rbin + fetch`, taken modulo 2^(ADDRSIZE+1) (natural wrap). `rgraynext = (rbinnext >> 1) ^ rbinnext`.
- Per-cycle register updates:
  - `rbin <= rbinnext`
  - `rptr <= rgraynext`
  - `rempty <= (rgraynext == rq2_wptr)`
- Read address: `raddr = rbin[ADDRSIZE-1:0]`, combinational from the register.
- Output stage:
  - If `fetch`: `dout <= rdata_mem`, `dout_valid <= 1`.
  - Else if `dout_ready`: `dout_valid <= 0`.
  - `dout` holds its value when not fetching.
- Level:
  - `wbin = gray2bin(rq2_wptr)`, where `wbin[i]` = XOR of `rq2_wptr[ADDRSIZE:i]`.
  - `rlevel <= wbin - rbinnext`, modulo 2^(ADDRSIZE+1).
  - The result is never greater than 2^ADDRSIZE when the write side honours `wfull`.
- Reset (`rrst` high at a clock edge) has priority over all other updates:
  - `rbin = 0`, `rptr = 0`, `rempty = 1`, `rlevel = 0`, `dout = 0`, `dout_valid = 0`.
  - `raddr` is therefore 0.
- Boundary conditions:
  - Empty: `rempty = 1` blocks fetch. `dout_valid` may still be 1, holding the final word until it is accepted.
  - Full (`rlevel = 2^ADDRSIZE`): the MSBs of the pointers differ and the lower bits are equal. This must not be reported as empty.
  - Wrap: `rbin` rolls from 2^(ADDRSIZE+1)-1 to 0. `rptr` changes exactly one bit on every increment, including the wrap.
  - Simultaneous accept and fetch: `dout` is replaced and `dout_valid` stays 1; no bubble.
  - `rq2_wptr` may advance by more than one position between cycles. Empty and level are computed from the sampled value only; there are no assumptions about step size.
  - Reset mid-stream: any word in flight in `dout` is discarded. The write domain must be reset in the same reset event.
  - `dout_ready` with `dout_valid = 0`: no effect.

## Timing
- Memory word becoming visible:
  - Cycle N: `rq2_wptr` changes so that it is no longer equal to `rptr`.
  - Edge ending N: `rempty` falls.
  - Cycle N+1: fetch occurs (if the output stage is free).
  - Cycle N+2: `dout_valid` is high.
- Fetch and release:
  - The fetch edge samples `rdata_mem` at the current `raddr`.
  - The same edge advances `rbin`, `raddr` and `rptr`.
  - The slot is released to the write side only after `rptr` crosses the two-flop synchronizer in the write domain.
- Throughput: with `dout_ready` held at 1 and the FIFO non-empty, one word per cycle.
- `rempty` is pessimistic: it deasserts at least 3 `rclk` cycles after the actual write because of the synchronizer delay, but it asserts in the same cycle as the last fetch.
- No combinational path from `dout_ready` or `rq2_wptr` to any output.

## Test plan
- Reset: hold `rrst = 1` for 2 cycles with `rq2_wptr = 5'b00011` → after release, `rptr = 0`, `raddr = 0`, `rempty = 1`, `dout_valid = 0`, `dout = 0`. First post-reset cycle → `rempty = 0`, `rlevel = 2`.
- Single word: from reset, set `rq2_wptr = 5'b00001`, `rdata_mem = 8'hA5` at `raddr` 0, `dout_ready = 0` → `rempty` falls after 1 cycle; `dout = A5` and `dout_valid = 1` one cycle later; `rptr = 5'b00001`; `rempty` returns to 1; `dout_valid` holds until `dout_ready` is pulsed.
- Streaming: `rq2_wptr` = Gray(10), `dout_ready` = 1, memory returns `raddr + 8'h10` → 10 consecutive `dout` values `10..19`, no bubbles, then `rempty = 1` and `rlevel = 0`.
- Backpressure: 4 words queued, `dout_ready` toggles 1,0,0,1,... → every word is delivered exactly once and in order; `rbin` advances only on fetch cycles.
- Full and wrap: drive `rq2_wptr` to 16 entries ahead (`rlevel = 16`, `rempty = 0`), then drain; repeat to pass `rbin` 31→0 → `rptr` changes by one bit per step, `rlevel` goes from 16 down to 0, and no false empty occurs at full.
- Reset mid-stream: assert `rrst` while `dout_valid = 1` and `rlevel = 7` → next cycle all outputs are at their reset values and the word in `dout` is dropped.

Source files
------------

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of an asynchronous FIFO: it owns the read pointer, the empty
// flag and the level count, and registers the memory read data behind a valid/ready stage.
module fifo_read_ctrl #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [DATASIZE-1:0] rdata_mem,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic [DATASIZE-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready
);

    logic [ADDRSIZE:0]   rbin_q, rbin_d;
    logic [ADDRSIZE:0]   rptr_q, rptr_d;
    logic                rempty_q, rempty_d;
    logic [ADDRSIZE:0]   rlevel_q, rlevel_d;
    logic [DATASIZE-1:0] dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                fetch;
    logic [ADDRSIZE:0]   wbin;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch can be inferred.
        fetch        = !rempty_q && (!dout_valid_q || dout_ready);
        rbin_d       = rbin_q + {{ADDRSIZE{1'b0}}, fetch};
        rptr_d       = (rbin_d >> 1) ^ rbin_d;
        rempty_d     = (rptr_d == rq2_wptr);
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;

        // Gray to binary: each bit is the XOR of all Gray bits at and above it.
        wbin[ADDRSIZE] = rq2_wptr[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            wbin[i] = wbin[i+1] ^ rq2_wptr[i];
        end
        rlevel_d = wbin - rbin_d;

        if (fetch) begin
            dout_d       = rdata_mem;
            dout_valid_d = 1'b1;
        end else if (dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge rclk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (rrst) begin
            rbin_q       <= '0;
            rptr_q       <= '0;
            rempty_q     <= 1'b1;
            rlevel_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            rbin_q       <= rbin_d;
            rptr_q       <= rptr_d;
            rempty_q     <= rempty_d;
            rlevel_q     <= rlevel_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign raddr      = rbin_q[ADDRSIZE-1:0];
    assign rptr       = rptr_q;
    assign rempty     = rempty_q;
    assign rlevel     = rlevel_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl: reset, single word, streaming, backpressure,
// full/wrap and mid-stream reset, with a combinational memory model driven from raddr.
module tb_fifo_read_ctrl;

    logic       rclk = 1'b0;
    logic       rrst;
    logic [4:0] rq2_wptr;
    logic [7:0] rdata_mem;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic [4:0] rlevel;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;

    logic [7:0] mem [16];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 rclk = ~rclk;

    assign rdata_mem = mem[raddr];

    fifo_read_ctrl #(.DATASIZE(8), .ADDRSIZE(4)) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .rq2_wptr   (rq2_wptr),
        .rdata_mem  (rdata_mem),
        .raddr      (raddr),
        .rptr       (rptr),
        .rempty     (rempty),
        .rlevel     (rlevel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] gray(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset(input logic [4:0] w);
        rrst       = 1'b1;
        rq2_wptr   = w;
        dout_ready = 1'b0;
        repeat (2) step();
        rrst = 1'b0;
    endtask

    task automatic fill_mem(input logic [7:0] base);
        for (int i = 0; i < 16; i++) mem[i] = base + 8'(i);
    endtask

    initial begin
        int n_acc;
        logic [4:0] prev_ptr;

        rrst       = 1'b1;
        rq2_wptr   = '0;
        dout_ready = 1'b0;
        fill_mem(8'h00);

        // Reset with a non-zero write pointer (Gray 00011 = binary 2)
        do_reset(5'b00011);
        check("rst_rptr",   32'(rptr),       32'd0);
        check("rst_raddr",  32'(raddr),      32'd0);
        check("rst_rempty", 32'(rempty),     32'd1);
        check("rst_valid",  32'(dout_valid), 32'd0);
        check("rst_dout",   32'(dout),       32'd0);
        check("rst_rlevel", 32'(rlevel),     32'd0);
        step();
        check("post_rst_rempty", 32'(rempty), 32'd0);
        check("post_rst_rlevel", 32'(rlevel), 32'd2);

        // Single word, consumer stalled
        do_reset(5'b00000);
        mem[0]   = 8'hA5;
        rq2_wptr = 5'b00001;
        step();
        check("single_rempty_fall", 32'(rempty),     32'd0);
        check("single_valid_pre",   32'(dout_valid), 32'd0);
        step();
        check("single_dout",   32'(dout),       32'hA5);
        check("single_valid",  32'(dout_valid), 32'd1);
        check("single_rptr",   32'(rptr),       32'd1);
        check("single_raddr",  32'(raddr),      32'd1);
        check("single_rempty", 32'(rempty),     32'd1);
        check("single_rlevel", 32'(rlevel),     32'd0);
        step();
        check("single_hold_valid", 32'(dout_valid), 32'd1);
        check("single_hold_dout",  32'(dout),       32'hA5);
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        check("single_accept_valid", 32'(dout_valid), 32'd0);
        check("single_accept_dout",  32'(dout),       32'hA5);

        // Streaming 10 words at full rate
        do_reset(5'b00000);
        fill_mem(8'h10);
        rq2_wptr   = gray(10);
        dout_ready = 1'b1;
        step();
        check("stream_rlevel0", 32'(rlevel), 32'd10);
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("stream_dout%0d", k),   32'(dout),       32'(8'h10 + k));
            check($sformatf("stream_valid%0d", k),  32'(dout_valid), 32'd1);
            check($sformatf("stream_rlevel%0d", k), 32'(rlevel),     32'(9 - k));
        end
        check("stream_rempty", 32'(rempty), 32'd1);
        step();
        check("stream_valid_drop", 32'(dout_valid), 32'd0);

        // Backpressure: ready pattern 1,0,0,1 repeating, 4 words queued
        do_reset(5'b00000);
        fill_mem(8'h40);
        rq2_wptr = gray(4);
        n_acc    = 0;
        for (int c = 0; c < 16; c++) begin
            check($sformatf("bp_raddr%0d", c), 32'(raddr), 32'(n_acc + int'(dout_valid)));
            dout_ready = (c % 4 == 0) || (c % 4 == 3);
            if (dout_valid && dout_ready) begin
                check($sformatf("bp_word%0d", n_acc), 32'(dout), 32'(8'h40 + n_acc));
                n_acc++;
            end
            step();
        end
        check("bp_count",  32'(n_acc),  32'd4);
        check("bp_rempty", 32'(rempty), 32'd1);

        // Full and wrap: two passes of 16 words, the second wrapping rbin 31 -> 0
        do_reset(5'b00000);
        fill_mem(8'h80);
        for (int pass = 0; pass < 2; pass++) begin
            dout_ready = 1'b1;
            rq2_wptr   = gray((pass + 1) * 16);
            step();
            check($sformatf("full_rempty_p%0d", pass), 32'(rempty), 32'd0);
            check($sformatf("full_rlevel_p%0d", pass), 32'(rlevel), 32'd16);
            for (int k = 1; k <= 16; k++) begin
                prev_ptr = rptr;
                step();
                check($sformatf("wrap_rptr_p%0d_%0d", pass, k), 32'(rptr),
                      32'(gray(pass * 16 + k)));
                check($sformatf("wrap_onebit_p%0d_%0d", pass, k),
                      32'($countones(prev_ptr ^ rptr)), 32'd1);
                check($sformatf("wrap_rlevel_p%0d_%0d", pass, k), 32'(rlevel), 32'(16 - k));
                check($sformatf("wrap_rempty_p%0d_%0d", pass, k), 32'(rempty), 32'(k == 16));
                check($sformatf("wrap_dout_p%0d_%0d", pass, k), 32'(dout), 32'(8'h80 + k - 1));
            end
            step();
            check($sformatf("wrap_valid_drop_p%0d", pass), 32'(dout_valid), 32'd0);
        end
        check("wrap_rptr_end",  32'(rptr),  32'd0);
        check("wrap_raddr_end", 32'(raddr), 32'd0);

        // Reset mid-stream with a word held in dout
        do_reset(5'b00000);
        fill_mem(8'hC0);
        rq2_wptr = gray(10);
        step();
        step();
        dout_ready = 1'b1;
        step();
        step();
        check("mid_pre_valid",  32'(dout_valid), 32'd1);
        check("mid_pre_rlevel", 32'(rlevel),     32'd7);
        rrst = 1'b1;
        step();
        check("mid_rptr",   32'(rptr),       32'd0);
        check("mid_raddr",  32'(raddr),      32'd0);
        check("mid_rempty", 32'(rempty),     32'd1);
        check("mid_rlevel", 32'(rlevel),     32'd0);
        check("mid_dout",   32'(dout),       32'd0);
        check("mid_valid",  32'(dout_valid), 32'd0);
        rrst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
